// File: rtl/io_intr_responder.sv
// Memory-mapped I/O responder: scratch RAM, CTRL/LOAD/COUNT/STATUS registers, intr/int_ack handshake.
// Define IO_TIMER_EN to build the countdown timer (LOAD, COUNT, CTRL.TEN/ARL); otherwise only the software trigger raises PEND.
module io_intr_responder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_cs,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        int_ack,
    output logic        intr,
    output logic [31:0] dout,
    output logic        dout_vld
);
    localparam int WA_W   = ADDR_W - 2;
    localparam int RAM_AW = $clog2(DEPTH);
    localparam logic [WA_W-1:0] RAM_END  = WA_W'(DEPTH);
    localparam logic [WA_W-1:0] CTRL_A   = WA_W'(32'h3F0 >> 2);
    localparam logic [WA_W-1:0] LOAD_A   = WA_W'(32'h3F4 >> 2);
    localparam logic [WA_W-1:0] COUNT_A  = WA_W'(32'h3F8 >> 2);
    localparam logic [WA_W-1:0] STATUS_A = WA_W'(32'h3FC >> 2);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_REL} state_t;

    logic [WA_W-1:0] word;
    logic            wr_en, rd_en;
    logic            sel_ram, sel_ctrl, sel_load, sel_count, sel_status;
    logic [31:0]     ram [DEPTH];
    logic [31:0]     rd_data;
    logic            ctrl_ie, ctrl_ten, ctrl_arl;
    logic [31:0]     load_q, count_q;
    logic            timer_ev;
    logic            pend, miss, sw_wr, ack_clr;
    state_t          state, state_n;
    logic            unused_addr;

    assign word        = addr[ADDR_W-1:2];
    assign unused_addr = ^{addr[31:ADDR_W], addr[1:0]};
    assign wr_en       = io_cs & io_wr;
    assign rd_en       = io_cs & io_rd & ~io_wr;
    assign sel_ram     = (word < RAM_END);
    assign sel_ctrl    = (word == CTRL_A);
    assign sel_load    = (word == LOAD_A);
    assign sel_count   = (word == COUNT_A);
    assign sel_status  = (word == STATUS_A);
    assign sw_wr       = wr_en & sel_status;
    assign ack_clr     = (state == REQ) & int_ack;

    always_ff @(posedge clk) begin
        if (wr_en && sel_ram)
            ram[word[RAM_AW-1:0]] <= din;
    end

`ifdef IO_TIMER_EN
    logic ev_q;

    assign timer_ev = ctrl_ten && (count_q == 32'd1);

    // The cycle after an event either reloads COUNT or stops the timer; a CPU CTRL write on that edge wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_ten <= 1'b0;
            ctrl_arl <= 1'b0;
            load_q   <= '0;
            count_q  <= '0;
            ev_q     <= 1'b0;
        end else begin
            ev_q <= timer_ev;
            if (wr_en && sel_load)
                load_q <= din;
            if (wr_en && sel_ctrl && din[0] && !ctrl_ten)
                count_q <= load_q;
            else if (ev_q && ctrl_arl)
                count_q <= load_q;
            else if (ctrl_ten && count_q != 32'd0)
                count_q <= count_q - 32'd1;
            if (wr_en && sel_ctrl) begin
                ctrl_ten <= din[0];
                ctrl_arl <= din[1];
            end else if (ev_q && !ctrl_arl) begin
                ctrl_ten <= 1'b0;
            end
        end
    end
`else
    assign ctrl_ten = 1'b0;
    assign ctrl_arl = 1'b0;
    assign load_q   = '0;
    assign count_q  = '0;
    assign timer_ev = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            ctrl_ie <= 1'b0;
        else if (wr_en && sel_ctrl)
            ctrl_ie <= din[2];
    end

    // A timer event or software set always beats a clear (software or acknowledge) on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
            miss <= 1'b0;
        end else begin
            pend <= timer_ev | (sw_wr & din[2]) | (pend & ~(sw_wr & din[0]) & ~ack_clr);
            miss <= (timer_ev & pend) | (miss & ~(sw_wr & din[1]));
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (pend && ctrl_ie) state_n = REQ;
            REQ: begin
                if (int_ack)               state_n = WAIT_REL;
                else if (!ctrl_ie || !pend) state_n = IDLE;
            end
            WAIT_REL: if (!int_ack)        state_n = IDLE;
            default:                       state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            intr  <= 1'b0;
        end else begin
            state <= state_n;
            intr  <= (state_n == REQ);
        end
    end

    always_comb begin
        rd_data = '0;
        if (sel_ram)         rd_data = ram[word[RAM_AW-1:0]];
        else if (sel_ctrl)   rd_data = {29'd0, ctrl_ie, ctrl_arl, ctrl_ten};
        else if (sel_load)   rd_data = load_q;
        else if (sel_count)  rd_data = count_q;
        else if (sel_status) rd_data = {30'd0, miss, pend};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= rd_en;
            if (rd_en)
                dout <= rd_data;
        end
    end
endmodule

// File: tb/tb_io_intr_responder.sv
// Self-checking bench for io_intr_responder: directed scenarios plus randomized bus/ack traffic against a behavioural model.
module tb_io_intr_responder;
    localparam int DEPTH = 64;
`ifdef IO_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif
    localparam logic [7:0] W_CTRL   = 8'hFC;
    localparam logic [7:0] W_LOAD   = 8'hFD;
    localparam logic [7:0] W_COUNT  = 8'hFE;
    localparam logic [7:0] W_STATUS = 8'hFF;

    logic        clk = 1'b0;
    logic        reset, io_cs, io_wr, io_rd, int_ack;
    logic [31:0] addr, din;
    logic        intr, dout_vld;
    logic [31:0] dout;

    int n_cmp = 0;
    int n_bad = 0;
    logic ack_hold = 1'b0;

    io_intr_responder #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .io_cs(io_cs), .io_wr(io_wr), .io_rd(io_rd),
        .addr(addr), .din(din), .int_ack(int_ack),
        .intr(intr), .dout(dout), .dout_vld(dout_vld)
    );

    always #5 clk = ~clk;

    // Behavioural model state: register contents, handshake phase as two booleans, and the read port.
    logic [31:0] mem [DEPTH];
    logic        m_ten, m_arl, m_ie, m_pend, m_miss, m_intr, m_held, m_reload_due, m_vld;
    logic [31:0] m_load, m_count, m_dout;
    bit          model_live = 1'b0;
    logic        t_wr, t_rd, t_sw, t_ev, n_intr, n_held, n_pend, n_miss, n_ten, n_arl, n_ie;
    logic [7:0]  t_w;
    logic [31:0] t_rdv, n_count, n_load;

    function automatic logic [31:0] model_read(input logic [7:0] w);
        if (w < 8'd64)     return mem[w[5:0]];
        if (w == W_CTRL)   return {29'd0, m_ie, m_arl, m_ten};
        if (w == W_LOAD)   return m_load;
        if (w == W_COUNT)  return m_count;
        if (w == W_STATUS) return {30'd0, m_miss, m_pend};
        return 32'd0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_ten = 0; m_arl = 0; m_ie = 0; m_pend = 0; m_miss = 0;
            m_intr = 0; m_held = 0; m_reload_due = 0; m_vld = 0;
            m_load = 0; m_count = 0; m_dout = 0;
            model_live = 1'b1;
        end else begin
            t_wr  = io_cs && io_wr;
            t_rd  = io_cs && io_rd && !io_wr;
            t_w   = addr[9:2];
            t_sw  = t_wr && (t_w == W_STATUS);
            t_ev  = m_ten && (m_count == 32'd1);
            t_rdv = model_read(t_w);

            n_intr = m_intr;
            n_held = m_held;
            if (m_intr) begin
                if (int_ack) begin
                    n_intr = 0;
                    n_held = 1;
                end else if (!m_ie || !m_pend) begin
                    n_intr = 0;
                end
            end else if (m_held) begin
                if (!int_ack) n_held = 0;
            end else if (m_pend && m_ie) begin
                n_intr = 1;
            end

            n_pend = t_ev || (t_sw && din[2]) || (m_pend && !(t_sw && din[0]) && !(m_intr && int_ack));
            n_miss = (t_ev && m_pend) || (m_miss && !(t_sw && din[1]));

            n_ten = m_ten; n_arl = m_arl; n_ie = m_ie; n_count = m_count; n_load = m_load;
            if (m_reload_due) begin
                if (m_arl) n_count = m_load;
                else       n_ten = 0;
            end else if (m_ten && m_count != 0) begin
                n_count = m_count - 1;
            end
            if (t_wr && t_w == W_CTRL) begin
                n_ten = TIMER && din[0];
                n_arl = TIMER && din[1];
                n_ie  = din[2];
                if (TIMER && din[0] && !m_ten) n_count = m_load;
            end
            if (t_wr && t_w == W_LOAD && TIMER) n_load = din;
            if (t_wr && t_w < 8'd64) mem[t_w[5:0]] = din;
            if (t_rd) m_dout = t_rdv;

            m_vld = t_rd;
            m_reload_due = t_ev;
            m_intr = n_intr; m_held = n_held; m_pend = n_pend; m_miss = n_miss;
            m_ten = n_ten; m_arl = n_arl; m_ie = n_ie; m_count = n_count; m_load = n_load;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("intr", {31'd0, intr}, {31'd0, m_intr});
            checkOutput("dout_vld", {31'd0, dout_vld}, {31'd0, m_vld});
            checkOutput("dout", dout, m_dout);
        end
    end

    task automatic applyStimulus(input logic rst, input logic cs, input logic wr, input logic rd,
                                 input logic [31:0] a, input logic [31:0] d, input logic ack);
        reset = rst; io_cs = cs; io_wr = wr; io_rd = rd; addr = a; din = d; int_ack = ack;
        @(negedge clk);
    endtask

    task automatic doWrite(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a, d, ack_hold);
    endtask

    task automatic doRead(input logic [31:0] a);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, a, $urandom, ack_hold);
    endtask

    task automatic doIdle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom, ack_hold);
    endtask

    logic [7:0]  r_w;
    logic [31:0] r_a, r_d;
    int          r_sel;

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkOutput("reset_intr", {31'd0, intr}, 32'd0);
        checkOutput("reset_vld", {31'd0, dout_vld}, 32'd0);
        checkOutput("reset_dout", dout, 32'd0);

        for (int i = 0; i < DEPTH; i++) doWrite(32'(i * 4), $urandom);

        // RAM write/read-back and an unmapped read
        doWrite(32'h010, 32'hDEADBEEF);
        doRead(32'h010);
        checkOutput("ram_rd_data", dout, 32'hDEADBEEF);
        checkOutput("ram_rd_vld", {31'd0, dout_vld}, 32'd1);
        doIdle(1);
        checkOutput("vld_one_cycle", {31'd0, dout_vld}, 32'd0);
        doRead(32'h200);
        checkOutput("unmapped_rd", dout, 32'd0);

`ifdef IO_TIMER_EN
        doWrite(32'h3F4, 32'd5);
        doWrite(32'h3F0, 32'h5);
        doIdle(5);
        checkOutput("timer_no_intr_yet", {31'd0, intr}, 32'd0);
        doRead(32'h3FC);
        checkOutput("timer_pend", dout, 32'd1);
        checkOutput("timer_intr", {31'd0, intr}, 32'd1);
        checkOutput("model_pend_pin", {31'd0, m_pend}, 32'd1);
        doRead(32'h3F0);
        checkOutput("ten_cleared", dout, 32'h4);
`else
        doWrite(32'h3F0, 32'h4);
        doWrite(32'h3FC, 32'h4);
        doIdle(1);
        checkOutput("sw_intr", {31'd0, intr}, 32'd1);
        checkOutput("model_intr_pin", {31'd0, m_intr}, 32'd1);
`endif

        // acknowledge handshake
        ack_hold = 1'b1;
        doIdle(1);
        checkOutput("ack_intr_low", {31'd0, intr}, 32'd0);
        doRead(32'h3FC);
        checkOutput("ack_pend_clr", dout, 32'd0);
        doIdle(2);
        checkOutput("ack_held_no_intr", {31'd0, intr}, 32'd0);
        ack_hold = 1'b0;
        doIdle(2);
        checkOutput("released_idle", {31'd0, intr}, 32'd0);

`ifdef IO_TIMER_EN
        doWrite(32'h3F4, 32'd3);
        doWrite(32'h3F0, 32'h3);
        doIdle(10);
        checkOutput("arl_no_intr", {31'd0, intr}, 32'd0);
        doRead(32'h3FC);
        checkOutput("arl_pend_miss", dout, 32'h3);
        doWrite(32'h3F0, 32'h7);
        doIdle(1);
        checkOutput("ie_late_intr", {31'd0, intr}, 32'd1);
        doWrite(32'h3F0, 32'h0);
        doWrite(32'h3FC, 32'h3);
        doIdle(2);
`endif

        // software trigger, IE drop while requesting, write-wins collision
        doWrite(32'h3F0, 32'h4);
        doWrite(32'h3FC, 32'h4);
        doIdle(1);
        checkOutput("swtrig_intr", {31'd0, intr}, 32'd1);
        doWrite(32'h3F0, 32'h0);
        checkOutput("ie_drop_same_edge", {31'd0, intr}, 32'd1);
        doIdle(1);
        checkOutput("ie_drop_intr_low", {31'd0, intr}, 32'd0);
        doRead(32'h3FC);
        checkOutput("ie_drop_pend_kept", dout, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h020, 32'h12345678, 1'b0);
        checkOutput("wr_rd_no_vld", {31'd0, dout_vld}, 32'd0);
        doRead(32'h020);
        checkOutput("wr_rd_write_applied", dout, 32'h12345678);

        // reset while requesting
        doWrite(32'h3F0, 32'h4);
        doIdle(1);
        checkOutput("pre_reset_intr", {31'd0, intr}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkOutput("reset_req_intr", {31'd0, intr}, 32'd0);
        doRead(32'h3F0);
        checkOutput("reset_ctrl", dout, 32'd0);
        doRead(32'h3FC);
        checkOutput("reset_status", dout, 32'd0);

        doWrite(32'h3F4, 32'd7);
        doRead(32'h3F4);
        checkOutput("load_readback", dout, TIMER ? 32'd7 : 32'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            r_sel = $urandom_range(0, 9);
            if (r_sel < 4)       r_w = 8'($urandom_range(0, 63));
            else if (r_sel == 4) r_w = W_CTRL;
            else if (r_sel == 5) r_w = W_LOAD;
            else if (r_sel == 6) r_w = W_COUNT;
            else if (r_sel == 7) r_w = W_STATUS;
            else if (r_sel == 8) r_w = 8'($urandom_range(64, 251));
            else                 r_w = 8'($urandom_range(0, 255));
            r_a = $urandom;
            r_a[9:2] = r_w;
            r_d = $urandom;
            if (r_w == W_LOAD) r_d = 32'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) ack_hold = ~ack_hold;
            applyStimulus(1'($urandom_range(0, 399) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_a, r_d, ack_hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
